// File: rtl/approx_ha_mul_pipe_if.sv
// approx_ha_mul_pipe_if
//   Bundles the operand stream, the product stream and the mode-table write
//   port of approx_ha_mul_pipe.
//   master : producer/consumer side (drives operands, out_ready, cfg writes)
//   slave  : multiplier side (drives in_ready, out_valid, p)
//   Signals: in_valid/in_ready/x/y   operand beat handshake
//            out_valid/out_ready/p   product beat handshake
//            cfg_we/cfg_grp/cfg_col/cfg_mode  mode-table write port
interface approx_ha_mul_pipe_if #(
    parameter int WIDTH = 8
);
    localparam int G  = WIDTH / 2;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int CW = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   x;
    logic [WIDTH-1:0]   y;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] p;
    logic               cfg_we;
    logic [GW-1:0]      cfg_grp;
    logic [CW-1:0]      cfg_col;
    logic [1:0]         cfg_mode;

    modport master (
        output in_valid, x, y, out_ready, cfg_we, cfg_grp, cfg_col, cfg_mode,
        input  in_ready, out_valid, p
    );

    modport slave (
        input  in_valid, x, y, out_ready, cfg_we, cfg_grp, cfg_col, cfg_mode,
        output in_ready, out_valid, p
    );
endinterface

// File: rtl/approx_ha_mul_pipe.sv
// approx_ha_mul_pipe
//   Three-stage approximate unsigned multiplier. Partial-product rows are
//   paired per group; each half-adder pair position uses a run-time mode
//   (EXACT / OR_SUM / ONLY_A / ELIM) from a writable mode table.
//   Ports: clk          rising-edge clock
//          rst_n        synchronous active-low reset
//          bus (slave)  operand/product handshakes and mode-table writes

// One row-pair group: rows a = y&x[2g], b = y&x[2g+1], combined pairwise.
module approx_ha_grp #(
    parameter int WIDTH = 8
) (
    input  logic                      xa,
    input  logic                      xb,
    input  logic [WIDTH-1:0]          y,
    input  logic [WIDTH-1:1][1:0]     mode,
    output logic [WIDTH:0]            t,
    output logic [WIDTH-2:0]          bo
);
    localparam int P = WIDTH - 1;

    logic [WIDTH-1:0] a, b;
    logic [P:1]       s, c;

    assign a = y & {WIDTH{xa}};
    assign b = y & {WIDTH{xb}};

    // Pair i adds a[i] and b[i-1] (b row is one column to the left).
    always_comb begin
        s = '0;
        c = '0;
        for (int i = 1; i <= P; i++) begin
            case (mode[i])
                2'b00:   begin s[i] = a[i] ^ b[i-1]; c[i] = a[i] & b[i-1]; end
                2'b01:   begin s[i] = a[i] | b[i-1]; c[i] = 1'b0;          end
                2'b10:   begin s[i] = 1'b0;          c[i] = a[i];          end
                default: begin s[i] = 1'b0;          c[i] = 1'b0;          end
            endcase
        end
    end

    // Carries of pairs 1..P-1 sit two columns above bo's base; the final
    // carry and the a[0] column fold into t.
    assign t  = {c[P], s, a[0]};
    assign bo = {b[WIDTH-1], c[P-1:1]};
endmodule

module approx_ha_mul_pipe #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    approx_ha_mul_pipe_if.slave    bus
);
    localparam int G  = WIDTH / 2;
    localparam int P  = WIDTH - 1;
    localparam int PW = 2 * WIDTH;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int CW = $clog2(WIDTH);

    logic [3:1]                 vld_pipe;
    logic [3:1]                 en;
    logic [G-1:0][P:1][1:0]     mode_q;

    logic [WIDTH-1:0]           x_q, y_q;
    logic [G-1:0][WIDTH:0]      t_d, t_q;
    logic [G-1:0][WIDTH-2:0]    bo_d, bo_q;
    logic [PW-1:0]              p_d, p_q;
    logic                       wr_ok;

    // A stage may advance when its successor advances or holds a bubble.
    assign en[3]        = bus.out_ready || !vld_pipe[3];
    assign en[2]        = en[3] || !vld_pipe[2];
    assign en[1]        = en[2] || !vld_pipe[1];
    assign bus.in_ready = en[1];
    assign bus.out_valid = vld_pipe[3];
    assign bus.p         = p_q;

    assign wr_ok = bus.cfg_we && (bus.cfg_col != '0) && (bus.cfg_col <= CW'(P))
                && ({1'b0, bus.cfg_grp} < (GW+1)'(G));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            p_q      <= '0;
            mode_q   <= '0;
        end else begin
            if (en[1]) vld_pipe[1] <= bus.in_valid;
            if (en[2]) vld_pipe[2] <= vld_pipe[1];
            if (en[3]) vld_pipe[3] <= vld_pipe[2];
            if (en[3] && vld_pipe[2]) p_q <= p_d;
            if (wr_ok) mode_q[bus.cfg_grp][bus.cfg_col] <= bus.cfg_mode;
        end
    end

    // Datapath registers carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (en[1] && bus.in_valid) begin
            x_q <= bus.x;
            y_q <= bus.y;
        end
        if (en[2] && vld_pipe[1]) begin
            t_q  <= t_d;
            bo_q <= bo_d;
        end
    end

    // Mode table is read combinationally as the beat leaves S1, so a write
    // in that same cycle only affects later beats.
    for (genvar g = 0; g < G; g++) begin : g_grp
        approx_ha_grp #(.WIDTH(WIDTH)) u_grp (
            .xa   (x_q[2*g]),
            .xb   (x_q[2*g+1]),
            .y    (y_q),
            .mode (mode_q[g]),
            .t    (t_d[g]),
            .bo   (bo_d[g])
        );
    end

    always_comb begin
        p_d = '0;
        for (int g = 0; g < G; g++)
            p_d = p_d + ((PW'(t_q[g]) + (PW'(bo_q[g]) << 2)) << (2 * g));
    end
endmodule

// File: tb/tb_approx_ha_mul_pipe.sv
module tb_approx_ha_mul_pipe;
    localparam int WIDTH = 8;
    localparam int G     = WIDTH / 2;
    localparam int P     = WIDTH - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    approx_ha_mul_pipe_if #(.WIDTH(WIDTH)) bus ();
    approx_ha_mul_pipe #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int     n_tests = 0;
    int     n_fail  = 0;
    longint exp_q[$];
    longint last_p  = 0;
    int     acc_cnt = 0;
    int     out_cnt = 0;
    bit     rand_rdy = 1'b0;
    logic [1:0] m_mode [G][WIDTH];

    task automatic chk(input string tag, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    // Reference: each pair contributes its value arithmetically by mode.
    function automatic longint model(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv);
        longint acc = 0;
        for (int g = 0; g < G; g++) begin
            logic [WIDTH-1:0] a, b;
            longint v;
            a = xv[2*g]   ? yv : '0;
            b = xv[2*g+1] ? yv : '0;
            v = longint'(a[0]) + (longint'(b[WIDTH-1]) << WIDTH);
            for (int i = 1; i <= P; i++) begin
                case (m_mode[g][i])
                    2'b00: v += (longint'(a[i]) + longint'(b[i-1])) << i;
                    2'b01: v += longint'(a[i] | b[i-1]) << i;
                    2'b10: v += longint'(a[i]) << (i + 1);
                    default: ;
                endcase
            end
            acc += v << (2 * g);
        end
        return acc;
    endfunction

    function automatic void model_reset();
        for (int g = 0; g < G; g++)
            for (int c = 0; c < WIDTH; c++)
                m_mode[g][c] = 2'b00;
    endfunction

    // Scoreboard: push on accept, pop on delivered product.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                out_cnt++;
                last_p = longint'(bus.p);
                if (exp_q.size() == 0) chk("spurious_out", longint'(bus.out_valid), 0);
                else                   chk("p", longint'(bus.p), exp_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.x, bus.y));
                acc_cnt++;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv);
        int k = 0;
        bus.in_valid = 1'b1;
        bus.x = xv;
        bus.y = yv;
        @(negedge clk);
        while (!bus.in_ready && k < 50) begin
            k++;
            @(negedge clk);
        end
        if (k >= 50) chk("send_timeout", k, 0);
        sync();
        bus.in_valid = 1'b0;
    endtask

    task automatic cfg(input int grp, input int col, input logic [1:0] md);
        bus.cfg_we   = 1'b1;
        bus.cfg_grp  = 2'(grp);
        bus.cfg_col  = 3'(col);
        bus.cfg_mode = md;
        sync();
        bus.cfg_we = 1'b0;
        if (col != 0 && col <= P && grp < G) m_mode[grp][col] = md;
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("drain_left", exp_q.size(), 0);
        sync();
    endtask

    logic [WIDTH-1:0] bpx [4];
    logic [WIDTH-1:0] bpy [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0, o0, k, lat;
        longint held;
        bus.in_valid = 1'b0; bus.x = '0; bus.y = '0; bus.out_ready = 1'b1;
        bus.cfg_we = 1'b0; bus.cfg_grp = '0; bus.cfg_col = '0; bus.cfg_mode = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_p", longint'(bus.p), 0);
        sync();

        // exact, latency
        send(8'd255, 8'd255);
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 10) begin
            lat++;
            @(negedge clk);
        end
        chk("latency", lat, 3);
        drain();
        chk("exact_255", last_p, 65025);

        // random exact traffic with random backpressure
        o0 = out_cnt;
        rand_rdy = 1'b1;
        for (int i = 0; i < 30; i++) send(8'($urandom), 8'($urandom));
        rand_rdy = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        chk("rand_count", out_cnt - o0, 30);

        // OR_SUM
        cfg(0, 2, 2'b01);
        send(8'd3, 8'd6);
        drain();
        chk("or_sum", last_p, 14);

        // ELIM
        cfg(3, 1, 2'b11);
        send(8'hC0, 8'h03);
        drain();
        chk("elim", last_p, 320);

        // random traffic under mixed modes
        cfg(1, 4, 2'b10);
        cfg(2, 7, 2'b01);
        o0 = out_cnt;
        for (int i = 0; i < 12; i++) send(8'($urandom), 8'($urandom));
        drain();
        chk("mixed_count", out_cnt - o0, 12);

        // mid-flight reset
        o0 = out_cnt;
        send(8'd7, 8'd9);
        send(8'd11, 8'd13);
        rst_n = 1'b0;
        sync();
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("flush_in_ready", bus.in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            chk("flush_out_valid", bus.out_valid, 0);
            @(negedge clk);
        end
        chk("flush_count", out_cnt - o0, 0);
        sync();
        send(8'd3, 8'd6);
        drain();
        chk("rst_mode_exact_a", last_p, 18);
        send(8'hC0, 8'h03);
        drain();
        chk("rst_mode_exact_b", last_p, 576);

        // out-of-range config writes
        cfg(0, 0, 2'b11);
        cfg(3, 0, 2'b01);
        send(8'd255, 8'd255);
        drain();
        chk("cfg_col0_ignored", last_p, 65025);

        // backpressure
        bpx[0] = 8'd10; bpy[0] = 8'd20;
        bpx[1] = 8'd30; bpy[1] = 8'd40;
        bpx[2] = 8'd50; bpy[2] = 8'd60;
        bpx[3] = 8'd70; bpy[3] = 8'd80;
        a0 = acc_cnt;
        o0 = out_cnt;
        k = 0;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.x = bpx[0]; bus.y = bpy[0];
        repeat (6) begin
            @(negedge clk);
            if (bus.in_ready) k++;
            sync();
            if (k < 4) begin bus.x = bpx[k]; bus.y = bpy[k]; end
        end
        @(negedge clk);
        chk("bp_accepted", acc_cnt - a0, 3);
        chk("bp_in_ready", bus.in_ready, 0);
        held = longint'(bus.p);
        @(negedge clk);
        chk("bp_p_hold", longint'(bus.p), held);
        chk("bp_out_valid", bus.out_valid, 1);
        sync();
        bus.out_ready = 1'b1;
        lat = 0;
        while (k < 4 && lat < 20) begin
            @(negedge clk);
            if (bus.in_ready) k++;
            lat++;
            sync();
        end
        bus.in_valid = 1'b0;
        drain();
        chk("bp_accepted_all", acc_cnt - a0, 4);
        chk("bp_out_count", out_cnt - o0, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
